a_channel_sink: RTL and testbench
=================================

A_CHANNEL_SINK -- requirements
Module: a_channel_sink

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 4, number of assembled messages held (power of 2, minimum 2).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports SHALL be as follows (clock and reset first):
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_valid  input  1  beat present on the A channel.
REQ-006 a_ready  output  1  sink can accept a beat this cycle.
REQ-007 a_opcode  input  4  message opcode, repeated on every beat.
REQ-008 a_beat  input  2  beat index within message, 0..3.
REQ-009 a_data  input  8  beat payload byte.
REQ-010 msg_valid  output  1  FIFO head holds an assembled message.
REQ-011 msg_ready  input  1  consumer takes the head message.
REQ-012 msg_opcode  output  4  opcode of the head message.
REQ-013 msg_data  output  32  payload of the head message; beat k in bits [8k+7:8k].
REQ-014 err_valid  output  1  one-cycle pulse on a protocol error.
REQ-015 err_code  output  2  error cause, valid while err_valid=1: 1 bad beat, 2 opcode mismatch, 3 illegal opcode.
REQ-016 msg_count  output  16  count of messages pushed into the FIFO; wraps 0xFFFF->0.

Function
REQ-017 A beat SHALL be accepted only in a cycle with a_valid=1 and a_ready=1.
REQ-018 a_ready SHALL equal (reset=0 AND FIFO not full), computed combinationally from registered state.
REQ-019 Every message SHALL be exactly 4 beats with indices 0,1,2,3 in order.
REQ-020 The FSM SHALL have two states: IDLE (expecting beat 0) and COLLECT (expecting beat 1..3, held in a 2-bit expected-index register).
REQ-021 In IDLE, an accepted legal beat 0 SHALL latch the opcode and store a_data in byte 0, set expected to 1, and move to COLLECT.
REQ-022 In COLLECT, an accepted matching beat SHALL store a_data in byte[expected]; if expected<3, expected increments; if expected=3, the message is pushed and the FSM returns to IDLE.
REQ-023 Opcodes 0..7 SHALL be legal; opcodes 8..15 SHALL be illegal.
REQ-024 Error checks SHALL apply to each accepted beat with priority: illegal opcode (3), then a_beat != expected (1; expected is 0 in IDLE), then opcode differs from the latched opcode (2; checked in COLLECT only).
REQ-025 On error, err_valid SHALL pulse the next cycle with err_code; the beat and any partial message SHALL be discarded; the FSM SHALL go to IDLE; msg_count SHALL be unchanged.
REQ-026 Latency: the final beat accepted in cycle N SHALL produce msg_valid=1 with the message at the FIFO head by cycle N+1 (when the FIFO was empty).
REQ-027 The FIFO SHALL be first-in first-out; the head pops when msg_valid=1 and msg_ready=1.
REQ-028 A push and a pop in the same cycle SHALL leave occupancy unchanged and preserve ordering.
REQ-029 When the FIFO is full, a_ready=0 and the FSM state SHALL hold; a pop in that cycle SHALL raise a_ready in the next cycle.
REQ-030 msg_opcode and msg_data SHALL be stable while msg_valid=1 and msg_ready=0.
REQ-031 msg_count SHALL increment by 1 on each push, modulo 2^16.

Reset
REQ-032 While reset=1: FSM goes to IDLE, expected=0, FIFO empty, msg_valid=0, err_valid=0, err_code=0, msg_count=0, a_ready=0; msg_opcode/msg_data=0.
REQ-033 Reset asserted mid-message SHALL discard the partial message with no error pulse; a_ready=1 in the first cycle after reset deasserts.

Verification
REQ-034 Single message: beats (op 5, idx 0..3, data 11,22,33,44) -> msg_valid one cycle after beat 3, msg_opcode=5, msg_data=0x44332211, msg_count=1.
REQ-035 Bad beat: beats idx 0, 2 (op 1) -> err_valid pulse with err_code=1; then a clean 4-beat message is received correctly.
REQ-036 Opcode mismatch / illegal opcode: beat0 op 2, beat1 op 3 -> err_code=2; beat0 op 9 -> err_code=3; no push in either case.
REQ-037 Backpressure: msg_ready=0 with FIFO_DEPTH=4 messages sent -> a_ready=0 after the 4th push; one pop -> a_ready=1 the next cycle; order preserved 1..5.
REQ-038 Reset after beat 1 of a message -> no message and no error; the following message is accepted normally; msg_count=1.
REQ-039 Wrap: preload msg_count near 0xFFFF (or send 65537 messages) -> msg_count wraps to 0 then 1.

Source files
------------

// File: rtl/a_channel_sink.sv
// A-channel sink: builds 4-beat messages from byte beats, checks the beat protocol
// and queues finished messages in a small FIFO for the consumer.
module a_channel_sink #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_opcode,
    input  logic [1:0]  a_beat,
    input  logic [7:0]  a_data,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic [3:0]  msg_opcode,
    output logic [31:0] msg_data,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [15:0] msg_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t      r_state;
    logic [1:0]  r_expected;
    logic [3:0]  r_opcode;
    logic [23:0] r_data;
    logic        r_err_valid;
    logic [1:0]  r_err_code;
    logic [15:0] r_msg_count;
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [3:0]  r_fifo_op   [FIFO_DEPTH];
    logic [31:0] r_fifo_data [FIFO_DEPTH];

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_exp;
    logic [1:0]  w_err;

    // Extra pointer bit separates full from empty when the indices match.
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    assign a_ready   = !reset && !w_full;
    assign w_accept  = a_valid && a_ready;
    assign msg_valid = !reset && !w_empty;
    assign w_pop     = msg_valid && msg_ready;
    assign w_exp     = (r_state == IDLE) ? 2'd0 : r_expected;

    always_comb begin
        w_err = 2'd0;
        if (a_opcode[3])
            w_err = 2'd3;
        else if (a_beat != w_exp)
            w_err = 2'd1;
        else if (r_state == COLLECT && a_opcode != r_opcode)
            w_err = 2'd2;
    end

    assign w_push = w_accept && (w_err == 2'd0) && (r_state == COLLECT) && (r_expected == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_expected  <= 2'd0;
            r_opcode    <= 4'd0;
            r_data      <= 24'd0;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'd0;
            r_msg_count <= 16'd0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_err_valid <= w_accept && (w_err != 2'd0);
            r_err_code  <= w_accept ? w_err : 2'd0;
            if (w_accept) begin
                if (w_err != 2'd0) begin
                    r_state    <= IDLE;
                    r_expected <= 2'd0;
                end else if (r_state == IDLE) begin
                    r_opcode     <= a_opcode;
                    r_data[7:0]  <= a_data;
                    r_expected   <= 2'd1;
                    r_state      <= COLLECT;
                end else if (r_expected != 2'd3) begin
                    if (r_expected == 2'd1)
                        r_data[15:8] <= a_data;
                    else
                        r_data[23:16] <= a_data;
                    r_expected <= r_expected + 2'd1;
                end else begin
                    r_state    <= IDLE;
                    r_expected <= 2'd0;
                end
            end
            if (w_push) begin
                r_wptr      <= r_wptr + 1'b1;
                r_msg_count <= r_msg_count + 16'd1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    // The last beat goes straight into the FIFO, so the message is visible next cycle.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wptr[AW-1:0]]   <= r_opcode;
            r_fifo_data[r_wptr[AW-1:0]] <= {a_data, r_data};
        end
    end

    assign msg_opcode = msg_valid ? r_fifo_op[r_rptr[AW-1:0]]   : 4'd0;
    assign msg_data   = msg_valid ? r_fifo_data[r_rptr[AW-1:0]] : 32'd0;
    assign err_valid  = !reset && r_err_valid;
    assign err_code   = reset ? 2'd0 : r_err_code;
    assign msg_count  = reset ? 16'd0 : r_msg_count;

endmodule

// File: tb/tb_a_channel_sink.sv
// Directed bench for a_channel_sink: message assembly, errors, backpressure,
// mid-message reset and message counter wrap.
module tb_a_channel_sink;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_opcode;
    logic [1:0]  a_beat;
    logic [7:0]  a_data;
    logic        msg_valid;
    logic        msg_ready;
    logic [3:0]  msg_opcode;
    logic [31:0] msg_data;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [15:0] msg_count;

    int total = 0;
    int bad   = 0;

    a_channel_sink #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_beat(a_beat), .a_data(a_data),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_opcode(msg_opcode), .msg_data(msg_data),
        .err_valid(err_valid), .err_code(err_code), .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [3:0] k);
        return {k, 4'h3, k, 4'h2, k, 4'h1, k, 4'h0};
    endfunction

    // Offers one beat from a negedge; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [3:0] op, input logic [1:0] idx,
                             input logic [7:0] d, input logic rdy);
        int n = 0;
        @(negedge clk);
        a_valid = 1'b1; a_opcode = op; a_beat = idx; a_data = d; msg_ready = rdy;
        while (!a_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) chk("ready_timeout", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0; msg_ready = 1'b0;
    endtask

    task automatic send_msg(input logic [3:0] op, input logic [31:0] d, input logic pop_last);
        for (int b = 0; b < 4; b++)
            send_beat(op, 2'(b), d[8*b +: 8], pop_last && (b == 3));
    endtask

    task automatic pop();
        @(negedge clk);
        msg_ready = 1'b1;
        @(posedge clk);
        #1;
        msg_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; a_valid = 1'b0; a_opcode = 4'd0; a_beat = 2'd0;
        a_data = 8'd0; msg_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_ready",   32'(a_ready),   32'd0);
        chk("rst_msg_valid", 32'(msg_valid), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_count",     32'(msg_count), 32'd0);
        chk("rst_data",      msg_data,       32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(a_ready), 32'd1);

        // single message
        send_msg(4'd5, 32'h44332211, 1'b0);
        chk("single_valid", 32'(msg_valid),  32'd1);
        chk("single_op",    32'(msg_opcode), 32'd5);
        chk("single_data",  msg_data,        32'h44332211);
        chk("single_count", 32'(msg_count),  32'd1);
        chk("single_noerr", 32'(err_valid),  32'd0);
        pop();
        chk("single_popped", 32'(msg_valid), 32'd0);

        // bad beat index, then clean message
        send_beat(4'd1, 2'd0, 8'h10, 1'b0);
        send_beat(4'd1, 2'd2, 8'h11, 1'b0);
        chk("badbeat_err",   32'(err_valid), 32'd1);
        chk("badbeat_code",  32'(err_code),  32'd1);
        chk("badbeat_count", 32'(msg_count), 32'd1);
        @(posedge clk);
        #1;
        chk("err_one_cycle", 32'(err_valid), 32'd0);
        send_msg(4'd3, 32'hA3A2A1A0, 1'b0);
        chk("clean_op",    32'(msg_opcode), 32'd3);
        chk("clean_data",  msg_data,        32'hA3A2A1A0);
        chk("clean_count", 32'(msg_count),  32'd2);
        pop();

        // opcode mismatch, illegal opcode, priorities
        send_beat(4'd2, 2'd0, 8'h01, 1'b0);
        send_beat(4'd3, 2'd1, 8'h02, 1'b0);
        chk("mismatch_err",  32'(err_valid), 32'd1);
        chk("mismatch_code", 32'(err_code),  32'd2);
        send_beat(4'd9, 2'd0, 8'h03, 1'b0);
        chk("illegal_code", 32'(err_code), 32'd3);
        send_beat(4'd9, 2'd2, 8'h04, 1'b0);
        chk("illegal_prio", 32'(err_code), 32'd3);
        send_beat(4'd2, 2'd1, 8'h05, 1'b0);
        chk("idle_badbeat", 32'(err_code), 32'd1);
        chk("err_nopush_count", 32'(msg_count), 32'd2);
        chk("err_nopush_valid", 32'(msg_valid), 32'd0);

        // backpressure: fill the FIFO, one pop reopens the channel
        for (int k = 1; k <= 4; k++)
            send_msg(4'(k), pat(4'(k)), 1'b0);
        chk("full_ready", 32'(a_ready),    32'd0);
        chk("full_count", 32'(msg_count),  32'd6);
        chk("full_head",  32'(msg_opcode), 32'd1);
        chk("full_data",  msg_data,        pat(4'd1));
        pop();
        chk("pop_reopens", 32'(a_ready), 32'd1);
        send_msg(4'd5, pat(4'd5), 1'b0);
        chk("refill_ready", 32'(a_ready), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            chk("order_op",   32'(msg_opcode), 32'(k));
            chk("order_data", msg_data,        pat(4'(k)));
            pop();
        end
        chk("drained", 32'(msg_valid), 32'd0);
        chk("bp_count", 32'(msg_count), 32'd7);

        // push and pop on the same edge
        send_msg(4'd6, pat(4'd6), 1'b0);
        send_msg(4'd7, pat(4'd7), 1'b1);
        chk("pushpop_valid", 32'(msg_valid),  32'd1);
        chk("pushpop_op",    32'(msg_opcode), 32'd7);
        chk("pushpop_data",  msg_data,        pat(4'd7));
        chk("pushpop_count", 32'(msg_count),  32'd9);
        pop();
        chk("pushpop_empty", 32'(msg_valid), 32'd0);

        // reset in the middle of a message
        send_beat(4'd4, 2'd0, 8'hE0, 1'b0);
        send_beat(4'd4, 2'd1, 8'hE1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(a_ready),   32'd0);
        chk("midrst_count", 32'(msg_count), 32'd0);
        chk("midrst_err",   32'(err_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_ready_after", 32'(a_ready),   32'd1);
        chk("midrst_no_msg",      32'(msg_valid), 32'd0);
        send_msg(4'd4, 32'hDDCCBBAA, 1'b0);
        chk("midrst_noerr", 32'(err_valid),  32'd0);
        chk("midrst_op",    32'(msg_opcode), 32'd4);
        chk("midrst_data",  msg_data,        32'hDDCCBBAA);
        chk("midrst_cnt1",  32'(msg_count),  32'd1);
        pop();

        // counter wrap from a preloaded value
        @(negedge clk);
        force dut.r_msg_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_msg_count;
        #1;
        chk("wrap_preload", 32'(msg_count), 32'hFFFE);
        send_msg(4'd1, pat(4'd1), 1'b0);
        chk("wrap_ffff", 32'(msg_count), 32'hFFFF);
        send_msg(4'd2, pat(4'd2), 1'b0);
        chk("wrap_zero", 32'(msg_count), 32'd0);
        send_msg(4'd3, pat(4'd3), 1'b0);
        chk("wrap_one", 32'(msg_count), 32'd1);
        chk("wrap_head", 32'(msg_opcode), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
